pc_fetch_unit: RTL

Program-counter and instruction-fetch stage of the 8-bit CPU. It holds the PC, fetches one instruction per PC from instruction memory over a req/ack handshake, and presents it to decode over a valid/ready handshake. On consumption it computes the next PC from the sign-extended jump offset supplied by the decode-side sign-extension stage. Sits between instruction memory and decode/sign-extend.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/next_pc_calc.sv | 14 +
 rtl/pc_fetch_unit.sv | 88 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and fetch-state type shared by the fetch, decode and sign-extend stages
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int INSTR_W = 8;
    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

    typedef enum logic [1:0] {
        FETCH,
        VALID,
        HALTED
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: sequential or jump successor of pc, modulo 2^ADDR_W
module next_pc_calc #(
    parameter int ADDR_W = cpu_pkg::ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_offset,
    output logic [ADDR_W-1:0] next_pc
);

    // offset is already sign-extended, so a plain modular add covers backward jumps
    always_comb next_pc = pc + ADDR_W'(1) + (jump_en ? jump_offset : '0);

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and instruction fetch stage; define JUMP_COUNT_EN to add the saturating jump_count output
module pc_fetch_unit import cpu_pkg::*; #(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_offset,
    input  logic               halt,
`ifdef JUMP_COUNT_EN
    output logic [7:0]         jump_count,
`endif
    output logic [ADDR_W-1:0]  pc
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] next_pc;
    logic              handshake;

    assign imem_addr = pc;
    assign handshake = instr_valid && instr_ready;

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc          (pc),
        .jump_en     (jump_en),
        .jump_offset (jump_offset),
        .next_pc     (next_pc)
    );

    // fetch FSM with registered req/valid; reset overrides a same-cycle ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= VALID;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                VALID: begin
                    if (handshake) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            state <= HALTED;
                        end else begin
                            pc       <= next_pc;
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                HALTED: ;
                default: begin
                    state       <= FETCH;
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b1;
                end
            endcase
        end
    end

`ifdef JUMP_COUNT_EN
    // count taken jumps that are actually consumed, sticking at the top value
    always_ff @(posedge clk) begin
        if (reset)
            jump_count <= '0;
        else if (handshake && jump_en && !halt && jump_count != 8'hFF)
            jump_count <= jump_count + 8'd1;
    end
`endif

endmodule
